// File: rtl/detokenizer_pkg.sv
// Shared token definitions for the detokenizer: tag codes, glyph constants, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package detokenizer_pkg;

    // Token tags, identical to the lexer's encoding.
    localparam logic [7:0] TAG_NUM    = 8'h00;
    localparam logic [7:0] TAG_OUT    = 8'h01;
    localparam logic [7:0] TAG_A      = 8'h02;
    localparam logic [7:0] TAG_EQ     = 8'h03;
    localparam logic [7:0] TAG_B      = 8'h04;
    localparam logic [7:0] TAG_C      = 8'h05;
    localparam logic [7:0] TAG_IF     = 8'h06;
    localparam logic [7:0] TAG_LPAREN = 8'h07;
    localparam logic [7:0] TAG_RPAREN = 8'h08;
    localparam logic [7:0] TAG_PLUS   = 8'h09;
    localparam logic [7:0] TAG_MINUS  = 8'h0a;
    localparam logic [7:0] TAG_SEMI   = 8'h0b;
    localparam logic [7:0] TAG_EOF    = 8'h0c;

    localparam logic [7:0] DEF_SEP_CHAR     = 8'h20;
    localparam logic [7:0] DEF_NL_CHAR      = 8'h0a;
    localparam logic [7:0] DEF_UNKNOWN_CHAR = 8'h3f;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // One expanded token: bytes[0] goes out first.
    typedef struct packed {
        logic [3:0][7:0] bytes;
        logic [2:0]      len;
        logic            eof;
    } glyph_t;

endpackage

// File: rtl/detokenizer_u8_to_dec3.sv
// Binary byte to up-to-three ASCII decimal digits plus significant digit count.
// Latency: combinational.
// Backpressure: none.
// Ports: value (in, 8) -> hundreds/tens/ones ASCII digits (out, 8 each), count 1..3 (out, 2).
module u8_to_dec3 (
    input  logic [7:0] value,
    output logic [7:0] hundreds,
    output logic [7:0] tens,
    output logic [7:0] ones,
    output logic [1:0] count
);

    logic [7:0] rem;
    logic [1:0] h;
    logic [3:0] t;

    always_comb begin
        rem = value;
        h   = 2'd0;
        t   = 4'd0;
        if (rem >= 8'd200) begin
            h   = 2'd2;
            rem = rem - 8'd200;
        end else if (rem >= 8'd100) begin
            h   = 2'd1;
            rem = rem - 8'd100;
        end
        // rem < 100 here, so nine conditional subtractions are enough.
        for (int i = 0; i < 9; i++) begin
            if (rem >= 8'd10) begin
                rem = rem - 8'd10;
                t   = t + 4'd1;
            end
        end
        hundreds = 8'h30 + {6'd0, h};
        tens     = 8'h30 + {4'd0, t};
        ones     = 8'h30 + rem;
        if (h != 2'd0)      count = 2'd3;
        else if (t != 4'd0) count = 2'd2;
        else                count = 2'd1;
    end

endmodule

// File: rtl/detokenizer.sv
// Expands 16-bit {tag, value} tokens into 1..4 ASCII bytes with separator/newline suffix.
// Latency: first byte valid the cycle after accept; n+1 cycles per n-byte token.
// Backpressure: I_READY low while a token is being emitted; O_DATA/O_VALID hold while O_READY=0.
// Ports: CLK, RST (async active-high); I_VALID/I_READY/I_DATA token in;
//        O_VALID/O_READY/O_DATA byte out; DONE sticky after EOF is fully emitted.
module detokenizer
    import detokenizer_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR     = DEF_SEP_CHAR,
    parameter logic [7:0] NL_CHAR      = DEF_NL_CHAR,
    parameter logic [7:0] UNKNOWN_CHAR = DEF_UNKNOWN_CHAR
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_VALID,
    output logic        I_READY,
    input  logic [15:0] I_DATA,
    output logic        O_VALID,
    input  logic        O_READY,
    output logic [7:0]  O_DATA,
    output logic        DONE
);

    state_t          state_q, state_d;
    logic [3:0][7:0] buf_q, buf_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            eof_q, eof_d;
    logic            i_ready_q, i_ready_d;
    logic            o_valid_q, o_valid_d;
    logic            done_q, done_d;

    logic [7:0]      tag;
    logic [7:0]      dec_h, dec_t, dec_o;
    logic [1:0]      dec_cnt;
    logic [3:0][7:0] chars;
    logic [1:0]      nchar;
    logic [7:0]      suffix;
    glyph_t          glyph;

    assign tag = I_DATA[15:8];

    u8_to_dec3 u_dec (
        .value    (I_DATA[7:0]),
        .hundreds (dec_h),
        .tens     (dec_t),
        .ones     (dec_o),
        .count    (dec_cnt)
    );

    // Glyph mux: printable characters first, then the suffix in the next slot.
    always_comb begin
        chars  = '0;
        nchar  = 2'd1;
        suffix = SEP_CHAR;
        case (tag)
            TAG_NUM: begin
                nchar = dec_cnt;
                case (dec_cnt)
                    2'd3:    begin chars[0] = dec_h; chars[1] = dec_t; chars[2] = dec_o; end
                    2'd2:    begin chars[0] = dec_t; chars[1] = dec_o; end
                    default: chars[0] = dec_o;
                endcase
            end
            TAG_OUT:    begin nchar = 2'd3; chars[0] = 8'h6f; chars[1] = 8'h75; chars[2] = 8'h74; end
            TAG_A:      chars[0] = 8'h61;
            TAG_EQ:     chars[0] = 8'h3d;
            TAG_B:      chars[0] = 8'h62;
            TAG_C:      chars[0] = 8'h63;
            TAG_IF:     begin nchar = 2'd2; chars[0] = 8'h69; chars[1] = 8'h66; end
            TAG_LPAREN: chars[0] = 8'h28;
            TAG_RPAREN: chars[0] = 8'h29;
            TAG_PLUS:   chars[0] = 8'h2b;
            TAG_MINUS:  chars[0] = 8'h2d;
            TAG_SEMI:   begin chars[0] = 8'h3b; suffix = NL_CHAR; end
            TAG_EOF:    begin
                nchar = 2'd3; chars[0] = 8'h45; chars[1] = 8'h4f; chars[2] = 8'h46;
                suffix = NL_CHAR;
            end
            default:    chars[0] = UNKNOWN_CHAR;
        endcase
        glyph.bytes        = chars;
        glyph.bytes[nchar] = suffix;
        glyph.len          = {1'b0, nchar} + 3'd1;
        glyph.eof          = (tag == TAG_EOF);
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        eof_d     = eof_q;
        done_d    = done_q;
        i_ready_d = 1'b0;
        o_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_VALID && i_ready_q) begin
                    state_d   = ST_EMIT;
                    buf_d     = glyph.bytes;
                    cnt_d     = glyph.len;
                    eof_d     = glyph.eof;
                    o_valid_d = 1'b1;
                end else begin
                    i_ready_d = !done_q;
                end
            end
            ST_EMIT: begin
                o_valid_d = 1'b1;
                if (O_READY) begin
                    buf_d = {8'h00, buf_q[3:1]};
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        o_valid_d = 1'b0;
                        if (eof_q) begin
                            state_d = ST_HALT;
                            done_d  = 1'b1;
                        end else begin
                            // Raising ready at the last beat gives n+1 cycles per token.
                            state_d   = ST_IDLE;
                            i_ready_d = 1'b1;
                        end
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            cnt_q     <= 3'd0;
            eof_q     <= 1'b0;
            done_q    <= 1'b0;
            i_ready_q <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            eof_q     <= eof_d;
            done_q    <= done_d;
            i_ready_q <= i_ready_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign I_READY = i_ready_q;
    assign O_VALID = o_valid_q;
    assign O_DATA  = buf_q[0];
    assign DONE    = done_q;

endmodule

// File: tb/tb_detokenizer.sv
// Self-checking bench for detokenizer against a string-based reference model.
// Latency: n/a.
// Backpressure: O_READY driven constant or random per token.
module tb_detokenizer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        I_VALID = 1'b0;
    logic        I_READY;
    logic [15:0] I_DATA = 16'h0000;
    logic        O_VALID;
    logic        O_READY = 1'b0;
    logic [7:0]  O_DATA;
    logic        DONE;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    detokenizer dut (
        .CLK     (CLK),
        .RST     (RST),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .I_DATA  (I_DATA),
        .O_VALID (O_VALID),
        .O_READY (O_READY),
        .O_DATA  (O_DATA),
        .DONE    (DONE)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: token -> text of the glyph, then suffix byte.
    task automatic build_expected(input logic [15:0] tok);
        string      s;
        logic [7:0] sfx;
        exp_q.delete();
        sfx = 8'h20;
        case (tok[15:8])
            8'h00: s = $sformatf("%0d", tok[7:0]);
            8'h01: s = "out";
            8'h02: s = "a";
            8'h03: s = "=";
            8'h04: s = "b";
            8'h05: s = "c";
            8'h06: s = "if";
            8'h07: s = "(";
            8'h08: s = ")";
            8'h09: s = "+";
            8'h0a: s = "-";
            8'h0b: begin s = ";";   sfx = 8'h0a; end
            8'h0c: begin s = "EOF"; sfx = 8'h0a; end
            default: s = "?";
        endcase
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(sfx);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_token(input logic [15:0] tok, input bit rnd);
        int         waited = 0;
        int         cyc = 0;
        int         k = 0;
        bit         fin = 0;
        bit         prev_stall = 0;
        logic [7:0] prev_dat = 8'h00;
        build_expected(tok);
        while (!I_READY && waited < 50) begin
            @(negedge CLK);
            waited++;
        end
        chk("in_ready_wait", I_READY, 1);
        if (!I_READY) return;
        I_VALID = 1'b1;
        I_DATA  = tok;
        @(negedge CLK);
        I_VALID = 1'b0;
        I_DATA  = 16'($urandom);
        chk("ready_drop", I_READY, 0);
        chk("first_valid", O_VALID, 1);
        while (!fin && cyc < 200) begin
            if (prev_stall) begin
                chk("stall_valid", O_VALID, 1);
                chk("stall_data", O_DATA, prev_dat);
            end
            O_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (O_VALID && O_READY) begin
                chk($sformatf("tok%04h_b%0d", tok, k), O_DATA, exp_q[k]);
                k++;
                if (k == exp_q.size()) fin = 1;
            end
            prev_stall = O_VALID && !O_READY;
            prev_dat   = O_DATA;
            @(negedge CLK);
            cyc++;
        end
        chk("all_bytes", fin, 1);
        chk("valid_after", O_VALID, 0);
        if (tok[15:8] == 8'h0c) begin
            chk("done_set", DONE, 1);
            chk("ready_halt", I_READY, 0);
        end else begin
            chk("ready_after", I_READY, 1);
            chk("done_clear", DONE, 0);
        end
    endtask

    initial begin
        logic [15:0] seq2 [6];
        logic [7:0]  tg;
        seq2 = '{16'h00ff, 16'h0100, 16'h0200, 16'h0300, 16'h0007, 16'h0b00};

        // Reset state
        #2;
        chk("rst_i_ready", I_READY, 0);
        chk("rst_o_valid", O_VALID, 0);
        chk("rst_o_data", O_DATA, 8'h00);
        chk("rst_done", DONE, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", I_READY, 1);

        // NUM 0, then the mixed sequence
        run_token(16'h0000, 0);
        foreach (seq2[i]) run_token(seq2[i], 0);

        // Stalled NUM 128, unknown tag, NUM 100
        run_token(16'h0080, 1);
        run_token(16'h3a00, 0);
        run_token(16'h0064, 1);

        // Random tokens (EOF excluded so the block keeps running)
        for (int n = 0; n < 40; n++) begin
            tg = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(13, 255))
                                             : 8'($urandom_range(0, 11));
            run_token({tg, 8'($urandom)}, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of "out"
        O_READY = 1'b1;
        I_VALID = 1'b1;
        I_DATA  = 16'h0100;
        @(negedge CLK);
        I_VALID = 1'b0;
        chk("mid_b0", O_DATA, 8'h6f);
        @(negedge CLK);
        chk("mid_b1", O_DATA, 8'h75);
        @(negedge CLK);
        O_READY = 1'b0;
        RST = 1'b1;
        #1;
        chk("async_o_valid", O_VALID, 0);
        chk("async_o_data", O_DATA, 8'h00);
        chk("async_i_ready", I_READY, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        run_token(16'h0500, 0);

        // EOF, then halt
        run_token(16'h0c00, 1);
        for (int n = 0; n < 6; n++) begin
            I_VALID = 1'b1;
            I_DATA  = 16'($urandom);
            O_READY = 1'b1;
            @(negedge CLK);
            chk("halt_ready", I_READY, 0);
            chk("halt_valid", O_VALID, 0);
            chk("halt_done", DONE, 1);
        end
        I_VALID = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
